decade_timer_ctrl: RTL and testbench
====================================

# decade_timer_ctrl

Run/pause/clear controller for a cascade of decimal digit counters. It sequences `DIGITS` mod-10 stages as one multi-digit BCD stopwatch/timer, advancing on a qualified `tick` pulse. It compares against an optional BCD target and latches a terminal event. It sits between the user-control debounce logic and the seven-segment display driver.

## Interface

**Parameters**
- `DIGITS`, default 4: number of cascaded decimal digits (1–8).

**Ports**
- `clk` — in, 1: system clock; all state updates on the rising edge.
- `reset` — in, 1: asynchronous, active-low reset.
- `tick` — in, 1: single-cycle count-enable pulse from the prescaler.
- `start` — in, 1: single-cycle pulse; begin or resume counting.
- `stop` — in, 1: single-cycle pulse; pause counting.
- `clear` — in, 1: single-cycle pulse; zero all digits and return to IDLE.
- `target_en` — in, 1: enables the target compare.
- `target` — in, 4*DIGITS: BCD target. Digit *i* is at [4i+3:4i]. Each digit must be ≤ 9.
- `count` — out, 4*DIGITS: current BCD value, same packing as `target`.
- `running` — out, 1: high in RUN.
- `done` — out, 1: high in DONE.
- `wrap` — out, 1: one-cycle pulse when the count rolls from all-9s to all-0s.

## Operation

**States:** IDLE, RUN, PAUSE, DONE.
- **IDLE:** `start` → RUN.
- **RUN:** `stop` → PAUSE. A target hit → DONE.
- **PAUSE:** `start` → RUN.
- **DONE:** holds `count` and ignores `start`/`stop`. Only `clear` leaves it.
- **Any state:** `clear` → IDLE, `count` = 0.

**Command priority (same cycle):** `clear` > `stop` > `start`.

**Counting**
- Digits advance only when state == RUN, `tick`=1, and there is no `clear`/`stop` that cycle.
- A simultaneous `stop` and `tick` means the tick is dropped.
- A `start` in the same cycle as a `tick` while in IDLE/PAUSE means the tick is dropped; counting begins with the next tick.

**Cascade**
- Digit 0 increments on an effective tick.
- Digit *i* increments when the effective tick is present and digits 0..i-1 are all 9.
- Any digit at 9 that increments becomes 0.

**Wrap**
- All digits at 9 plus an effective tick → `count` = 0 and `wrap` = 1 for one cycle. The state stays in RUN.

**Target compare**
- Evaluated on the next-count value.
- If `target_en`=1 and the next count == `target`, the state becomes DONE on that same edge, with `count` = `target`.
- `target_en`=0: free-running; DONE is never entered.
- Target 0 is reached only via wrap. In that case both `wrap` and `done` are asserted.

**Input changes**
- Changing `target` or `target_en` while in RUN takes effect on the next tick.
- A target already passed is not matched until after wrap.

**Reset**
- Any time, including mid-count: state = IDLE, `count` = 0, and `running`, `done`, `wrap` = 0 immediately.

## Timing

- All outputs are registered. There is no combinational input-to-output path.
- **Latency:** a qualifying tick at edge N makes `count` visible after edge N. `done`/`wrap` assert on the same edge as the count update.
- `start` sampled at edge N makes `running`=1 after edge N. The first tick that can count is sampled at edge N+1.
- `stop` at edge N makes `running`=0 after N. A tick at N is not counted.
- `clear` at edge N makes `count`=0 and IDLE after N.
- There is no backpressure; inputs are assumed to be single-cycle pulses. A held `start` is harmless: it is re-applied every cycle and is idempotent.

## Structure

- **Shared package/header** `timer_pkg`: state encodings (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3) and the BCD digit width constant (4).
- **Sub-module** `decade_digit`:
  - Inputs: `clk`, `reset`, `en`, `clr`.
  - Outputs: `q[3:0]`, `tc` (q==9).
  - Instantiated `DIGITS` times via generate.
  - Each digit's enable is the effective tick AND the carry chain of lower-digit `tc`.
- The top level holds the FSM, cascade enables, next-count compare, and `wrap` register.

## Test plan

- **Reset and count:** reset low, then release; `start`, then 12 ticks (DIGITS=4) → `count`=0x0012, `running`=1, `done`=0.
- **Pause and clear priority:**
  - `stop` coincident with a tick at count 0x0005 → `count` stays 0x0005, state PAUSE.
  - `start` then 1 tick → 0x0006.
  - `clear`+`start` together → `count`=0, IDLE.
- **Wrap:** preload to 0x9999 by ticking, `target_en`=0; one tick → `count`=0x0000, `wrap` high exactly one cycle, `running` stays 1.
- **Target:**
  - `target`=0x0100, `target_en`=1; run 100 ticks → `done`=1 on the 100th tick edge, `count`=0x0100.
  - Further ticks and `start` → no change.
  - `clear` → IDLE, 0x0000.
- **Asynchronous reset mid-run:** assert `reset` low between clock edges at count 0x0047 → `count`=0 and `running`=0 before the next edge; ticks ignored while reset is low.
- **Carry chain:** DIGITS=2, count 0x09, one tick → 0x10; at 0x99 one tick → 0x00 with `wrap`.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the decade timer: controller state encoding,
// BCD digit width and the single-digit BCD increment used by every stage.
package timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Mod-10 increment of one BCD digit; 9 rolls over to 0.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    if (d == 4'd9) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/decade_digit.sv
// One mod-10 counter stage; tc flags the digit sitting at 9 so the next
// stage up can be enabled on the following carry.
module decade_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [BCD_W-1:0] q,
  output logic             tc
);

  logic [BCD_W-1:0] q_d;
  logic [BCD_W-1:0] q_q;

  // Next digit value: clear wins over increment.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 4'd0;
    end else if (en) begin
      q_d = bcd_inc(q_q);
    end else begin
      q_d = q_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  assign tc = (q_q == 4'd9);

endmodule

// File: rtl/decade_timer_ctrl.sv
// Run/pause/clear controller for a cascade of BCD digits with optional
// target compare, terminal DONE state and registered wrap pulse.
module decade_timer_ctrl
  import timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  target_en,
  input  logic [4*DIGITS-1:0]   target,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  done,
  output logic                  wrap
);

  state_e                state_d;
  state_e                state_q;
  logic                  running_q;
  logic                  done_q;
  logic                  wrap_d;
  logic                  wrap_q;
  logic                  eff_tick_s;
  logic                  hit_s;
  logic [DIGITS:0]       carry_s;
  logic [DIGITS-1:0]     tc_s;
  logic [4*DIGITS-1:0]   next_count_s;

  // Stop and clear both suppress a coincident tick; a start in IDLE/PAUSE
  // drops it implicitly because the state is not yet RUN.
  assign eff_tick_s = (state_q == ST_RUN) & tick & ~clear & ~stop;
  assign carry_s[0] = eff_tick_s;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    decade_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (carry_s[i]),
      .clr   (clear),
      .q     (count[BCD_W*i +: BCD_W]),
      .tc    (tc_s[i])
    );
    assign carry_s[i+1] = carry_s[i] & tc_s[i];
  end

  // Value the digits will hold after this edge, used for the target compare.
  always_comb begin
    next_count_s = count;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry_s[i]) begin
        next_count_s[BCD_W*i +: BCD_W] = bcd_inc(count[BCD_W*i +: BCD_W]);
      end else begin
        next_count_s[BCD_W*i +: BCD_W] = count[BCD_W*i +: BCD_W];
      end
    end
  end

  assign hit_s  = eff_tick_s & target_en & (next_count_s == target);
  assign wrap_d = carry_s[DIGITS];

  // Next-state logic with clear > stop > start priority.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (hit_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered status outputs, all updated on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
      wrap_q    <= wrap_d;
    end
  end

  assign running = running_q;
  assign done    = done_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_decade_timer_ctrl.sv
// Self-checking bench: directed scenarios plus randomized commands, compared
// every cycle against an integer-valued reference model of the timer.
module tb_decade_timer_ctrl;

  localparam int DIGITS = 4;
  localparam int MOD    = 10000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic                target_en = 1'b0;
  logic [4*DIGITS-1:0] target = '0;
  logic [4*DIGITS-1:0] count;
  logic                running, done, wrap;

  int n_checks = 0;
  int n_errors = 0;
  int m_st = M_IDLE;
  int m_cnt = 0;
  bit m_wrap = 1'b0;

  decade_timer_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .target_en(target_en), .target(target),
    .count(count), .running(running), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [4*DIGITS-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS-1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count",   32'(count),   32'(to_bcd(m_cnt)));
    check("running", 32'(running), 32'(m_st == M_RUN));
    check("done",    32'(done),    32'(m_st == M_DONE));
    check("wrap",    32'(wrap),    32'(m_wrap));
  endtask

  // Reference behaviour for one clock edge, expressed on an integer count.
  task automatic model_edge(input bit t, input bit s, input bit p, input bit c);
    m_wrap = 1'b0;
    if (c) begin
      m_st = M_IDLE;
      m_cnt = 0;
    end else if (m_st == M_IDLE || m_st == M_PAUSE) begin
      if (s) m_st = M_RUN;
    end else if (m_st == M_RUN) begin
      if (p) begin
        m_st = M_PAUSE;
      end else if (t) begin
        m_cnt = (m_cnt + 1) % MOD;
        m_wrap = (m_cnt == 0);
        if (target_en && m_cnt == from_bcd(target)) m_st = M_DONE;
      end
    end
  endtask

  task automatic step(input bit t, input bit s, input bit p, input bit c);
    tick = t; start = s; stop = p; clear = c;
    @(posedge clk);
    model_edge(t, s, p, c);
    @(negedge clk);
    tick = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    @(negedge clk);
    check_all();

    // Start then 12 ticks; a start+tick in IDLE drops the tick
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(12);
    check("count_12", 32'(count), 32'h0012);

    // Stop coincident with tick, resume, clear beats start
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(5);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("stop_hold", 32'(count), 32'h0005);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    check("resume", 32'(count), 32'h0006);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("clear_prio", 32'(running), 32'h0);

    // Wrap from all nines (carry through every digit on the way)
    target_en = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(9999);
    check("preload", 32'(count), 32'h9999);
    ticks(1);
    check("wrap_pulse", 32'(wrap), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_once", 32'(wrap), 32'h0);

    // Target hit, then DONE ignores ticks and start
    step(1'b0, 1'b0, 1'b0, 1'b1);
    target = 16'h0100; target_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(100);
    check("target_done", 32'(done), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    ticks(3);
    check("done_hold", 32'(count), 32'h0100);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    target_en = 1'b0;

    // Asynchronous reset between edges at 0x0047
    step(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(47);
    #2 reset = 1'b0;
    #1;
    check("async_cnt", 32'(count), 32'h0);
    check("async_run", 32'(running), 32'h0);
    m_st = M_IDLE; m_cnt = 0; m_wrap = 1'b0;
    tick = 1'b1; start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ticks", 32'(count), 32'h0);
    tick = 1'b0; start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_all();

    // Randomized commands with targets placed near the current count
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        target_en = 1'($urandom_range(0, 1));
        target = to_bcd((m_cnt + int'($urandom_range(1, 30))) % MOD);
      end
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 80) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
